switch_gather_transpose: RTL
============================

// Module: switch_gather_transpose
// PURPOSE
// - Return path of the PE<->memory-group switch network.
// - Collects PE result beats (one element per PE lane per beat) and re-transposes each NUM_MG x NUM_PE tile into memory-group order.
// - Result: output beat m carries every element destined for memory group m.
// - Ping-pong tile buffer with valid/ready on both sides; sustains one beat/cycle.
// PARAMETERS
// - DATA_WIDTH  64  width of one coefficient element
// - NUM_PE      8   PE lanes per input beat; must equal NUM_MG (elaboration $error otherwise)
// - NUM_MG      8   memory groups = beats per tile = output beats per tile
// PORTS
// - clk        in   1                    single clock, rising edge
// - rst        in   1                    asynchronous, active-high reset
// - in_valid   in   1                    input beat valid
// - in_ready   out  1                    block accepts input beat this cycle
// - in_data    in   [DATA_WIDTH-1:0] x [0:NUM_PE-1]   lane p = element from PE p
// - out_valid  out  1                    output beat valid
// - out_ready  in   1                    downstream accepts output beat
// - out_data   out  [DATA_WIDTH-1:0] x [0:NUM_PE-1]   lane k = element k for group out_mg
// - out_mg     out  $clog2(NUM_MG)       memory-group index of current output beat
// - out_last   out  1                    high on the final beat (out_mg==NUM_MG-1) of a tile
// - tiles_done out  16                   present only with GATHER_TILE_CNT_EN
// BEHAVIOUR
// Tile definition
// - Input beats b=0..NUM_MG-1 form tile T[b][p] = in_data[p] at beat b.
// - Output beat m drives out_data[k] = T[k][m] and out_mg = m.
// Handshakes
// - Transfer occurs when valid && ready. out_valid is held with data stable until accepted.
// - in_ready does not depend combinationally on in_valid.
// Banks
// - Two banks, each with state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
// - Write pointer wb, write counter wcnt; read pointer rb, read counter rcnt.
// - in_ready = bank[wb] is EMPTY or FILLING.
// - Accept: store at row wcnt. When wcnt==NUM_MG-1: bank->FULL, wcnt->0, wb toggles.
// - out_valid = bank[rb] is FULL or DRAINING. All outputs are registered.
// - Accepted output: rcnt increments. When rcnt==NUM_MG-1: bank->EMPTY, rcnt->0, rb toggles.
// Latency and throughput
// - First output beat is visible the cycle after the NUM_MG-th input of a tile is accepted.
// - Back-to-back tiles sustain 1 beat/cycle in and out with out_ready tied high.
// Boundary conditions
// - Both banks full: in_ready=0 until the draining bank empties. That bank frees in the same cycle its last beat is accepted, so in_ready rises the next cycle.
// - Simultaneous last input and last output on the same bank index is impossible (exclusive states).
// - On different banks, both transitions complete in that cycle.
// - out_ready low mid-tile: rcnt, out_data and out_mg are frozen.
// - Reset (any time, including mid-tile): both banks EMPTY, wb=rb=0, wcnt=rcnt=0.
//   - Reset outputs: in_ready=1, out_valid=0, out_data all 0, out_mg=0, out_last=0, tiles_done=0.
//   - Partial tiles are discarded; buffer contents need not be cleared.
// CONFIGURATION
// - GATHER_TILE_CNT_EN defined:
//   - Adds output tiles_done[15:0], incremented on each accepted out_last beat.
//   - Wraps 16'hFFFF -> 0. Reset value is 0.
// - Not defined: port and counter are absent; all other behaviour is identical.
// TESTING (DATA_WIDTH=64, NUM_PE=NUM_MG=8; input beat b lane p = 16*b+p)
// - Single tile, out_ready=1:
//   - 8 beats in -> out beat m lane k = 16*k+m.
//   - out_mg sequence 0..7; out_last only at m=7.
//   - First out_valid the cycle after the 8th accept.
// - 4 tiles streamed, in_valid=out_ready=1 (tile t adds 256*t):
//   - in_ready never drops after the first tile.
//   - 32 output beats, contiguous, correctly transposed.
// - out_ready=0 while 3 tiles offered:
//   - in_ready falls after 16 accepts.
//   - Raise out_ready -> in_ready returns 1 cycle after beat 8 of tile 0 drains.
//   - No data lost.
// - Random out_ready with 30% stall over 20 tiles:
//   - out_data/out_mg stable while out_valid && !out_ready.
//   - Scoreboard matches transpose.
// - Assert rst after 5 beats of tile 0:
//   - out_valid=0, in_ready=1.
//   - Next full tile outputs only its own data, out_mg starting at 0.
// - GATHER_TILE_CNT_EN: 3 tiles -> tiles_done=3. Preload 16'hFFFF via force, one tile -> 0.

Source files
------------

// File: rtl/switch_gather_transpose_if.sv
// Stream bundle for the gather/transpose return path: PE-ordered input beats in,
// memory-group-ordered output beats out.
interface switch_gather_transpose_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8,
  parameter int NUM_MG     = 8
);
  localparam int MG_W = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0]    in_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0]    out_data;
  logic [MG_W-1:0]                      out_mg;
  logic                                 out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mg, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mg, out_last
  );
endinterface

// File: rtl/switch_gather_transpose.sv
// Ping-pong tile buffer that re-transposes PE result beats into memory-group order.
// Optional tiles_done counter enabled by defining GATHER_TILE_CNT_EN.
module switch_gather_transpose #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8,
  parameter int NUM_MG     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  switch_gather_transpose_if.slave bus
`ifdef GATHER_TILE_CNT_EN
  ,
  output logic [15:0]              tiles_done
`endif
);
  localparam int CW = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_MG - 1);

  typedef logic [NUM_PE-1:0][DATA_WIDTH-1:0] beat_t;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;

  if (NUM_PE != NUM_MG) begin : g_shape_chk
    $error("switch_gather_transpose: NUM_PE must equal NUM_MG");
  end

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic            wb_q, wb_d, rb_q, rb_d;
  logic [CW-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  beat_t           mem_q [2][NUM_MG];

  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [CW-1:0]   out_mg_q;
  beat_t           out_data_q, out_data_d;

  logic            wr_fire, rd_fire;

  assign wr_fire = bus.in_valid && in_ready_q;
  assign rd_fire = out_valid_q && bus.out_ready;

  // Bank state machines and pointers
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wb_d      = wb_q;
    wcnt_d    = wcnt_q;
    rb_d      = rb_q;
    rcnt_d    = rcnt_q;
    if (wr_fire) begin
      if (wcnt_q == LAST_IDX) begin
        bank_d[wb_q] = B_FULL;
        wcnt_d       = '0;
        wb_d         = ~wb_q;
      end else begin
        bank_d[wb_q] = B_FILLING;
        wcnt_d       = wcnt_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rcnt_q == LAST_IDX) begin
        bank_d[rb_q] = B_EMPTY;
        rcnt_d       = '0;
        rb_d         = ~rb_q;
      end else begin
        bank_d[rb_q] = B_DRAINING;
        rcnt_d       = rcnt_q + 1'b1;
      end
    end
  end

  // Registered outputs are computed from next state; the row being written this
  // cycle is bypassed so a tile completing now can be presented next cycle.
  always_comb begin
    in_ready_d  = (bank_d[wb_d] == B_EMPTY) || (bank_d[wb_d] == B_FILLING);
    out_valid_d = (bank_d[rb_d] == B_FULL)  || (bank_d[rb_d] == B_DRAINING);
    out_last_d  = out_valid_d && (rcnt_d == LAST_IDX);
    out_data_d  = '0;
    for (int k = 0; k < NUM_MG; k++) begin
      if (wr_fire && (wb_q == rb_d) && (wcnt_q == CW'(k)))
        out_data_d[k] = bus.in_data[rcnt_d];
      else
        out_data_d[k] = mem_q[rb_d][k][rcnt_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= B_EMPTY;
      bank_q[1]   <= B_EMPTY;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_mg_q    <= '0;
      out_data_q  <= '0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_mg_q    <= rcnt_d;
      out_data_q  <= out_data_d;
    end
  end

  // Tile storage carries no reset; partial tiles are simply overwritten
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wb_q][wcnt_q] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mg    = out_mg_q;
  assign bus.out_last  = out_last_q;

`ifdef GATHER_TILE_CNT_EN
  logic [15:0] tiles_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       tiles_done_q <= '0;
    else if (rd_fire && out_last_q) tiles_done_q <= tiles_done_q + 16'd1;
  end

  assign tiles_done = tiles_done_q;
`endif
endmodule
